// File: rtl/fir_stream_loader.sv
// Buffers LENGTH coefficients, then replays coefficients, settle gap, lead, samples, pads and stop.
// Outputs are registered; once the flag sequence starts nothing stalls it, and a missing sample becomes a 0 slot.
module fir_stream_loader #(
  parameter int LENGTH        = 20,
  parameter int COEFF_W       = 8,
  parameter int DATA_W        = 8,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 20,
  parameter int LEAD_CYCLES   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic [COEFF_W-1:0] coeff_in,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               load_coefficients_flag,
  output logic               load_data_flag,
  output logic               stop_data_load_flag,
  output logic [COEFF_W-1:0] coefficient_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_COEFF_CAPTURE, S_COEFF_FLAG, S_COEFF_STREAM, S_COEFF_SETTLE,
    S_DATA_LEAD, S_DATA_STREAM, S_PAD, S_STOP
  } state_t;

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNT_W-1:0] LEN_LAST    = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] PAD_LAST    = CNT_W'((LENGTH > 1) ? LENGTH - 2 : 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST   = CNT_W'(LEAD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [COEFF_W-1:0] bank_q [LENGTH];
  logic [COEFF_W-1:0] bank_d [LENGTH];
  logic               underrun_q, underrun_d;
  logic               coeff_ready_q, coeff_ready_d;
  logic               sample_ready_q, sample_ready_d;
  logic               load_coeff_q, load_coeff_d;
  logic               load_data_q, load_data_d;
  logic               stop_q, stop_d;
  logic [COEFF_W-1:0] coeff_out_q, coeff_out_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    bank_d     = bank_q;
    underrun_d = underrun_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d      = num_samples;
          underrun_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_COEFF_CAPTURE;
        end
      end
      S_COEFF_CAPTURE: begin
        if (coeff_valid && coeff_ready_q) begin
          bank_d[cnt_q[IDX_W-1:0]] = coeff_in;
          if (cnt_q == LEN_LAST) begin
            cnt_d   = '0;
            state_d = S_COEFF_FLAG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COEFF_FLAG: begin
        cnt_d   = '0;
        state_d = S_COEFF_STREAM;
      end
      S_COEFF_STREAM: begin
        if (cnt_q == LEN_LAST) begin
          cnt_d   = '0;
          state_d = S_COEFF_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COEFF_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA_LEAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA_LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          cnt_d = '0;
          if (num_q != '0)     state_d = S_DATA_STREAM;
          else if (LENGTH > 1) state_d = S_PAD;
          else                 state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA_STREAM: begin
        // A missing sample still consumes its slot so the run length stays fixed.
        if (!sample_valid) underrun_d = 1'b1;
        if (cnt_q == num_q - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = (LENGTH > 1) ? S_PAD : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAD: begin
        if (cnt_q == PAD_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    coeff_ready_d  = (state_d == S_COEFF_CAPTURE);
    sample_ready_d = (state_d == S_DATA_STREAM);
    load_coeff_d   = !(state_d inside {S_IDLE, S_COEFF_CAPTURE});
    load_data_d    = state_d inside {S_DATA_LEAD, S_DATA_STREAM, S_PAD, S_STOP};
    stop_d         = (state_d == S_STOP);
    coeff_out_d    = (state_d == S_COEFF_STREAM) ? bank_q[cnt_d[IDX_W-1:0]] : '0;
    data_out_d     = (state_q == S_DATA_STREAM && sample_valid) ? sample_in : '0;
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_q == S_STOP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      num_q          <= '0;
      for (int i = 0; i < LENGTH; i++) bank_q[i] <= '0;
      underrun_q     <= 1'b0;
      coeff_ready_q  <= 1'b0;
      sample_ready_q <= 1'b0;
      load_coeff_q   <= 1'b0;
      load_data_q    <= 1'b0;
      stop_q         <= 1'b0;
      coeff_out_q    <= '0;
      data_out_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      num_q          <= num_d;
      bank_q         <= bank_d;
      underrun_q     <= underrun_d;
      coeff_ready_q  <= coeff_ready_d;
      sample_ready_q <= sample_ready_d;
      load_coeff_q   <= load_coeff_d;
      load_data_q    <= load_data_d;
      stop_q         <= stop_d;
      coeff_out_q    <= coeff_out_d;
      data_out_q     <= data_out_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign coeff_ready            = coeff_ready_q;
  assign sample_ready           = sample_ready_q;
  assign load_coefficients_flag = load_coeff_q;
  assign load_data_flag         = load_data_q;
  assign stop_data_load_flag    = stop_q;
  assign coefficient_out        = coeff_out_q;
  assign data_out               = data_out_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign underrun               = underrun_q;

endmodule

// File: tb/tb_fir_stream_loader.sv
// Random-stimulus bench: each run's whole output trace is predicted up front from the
// phase lengths and queued; a negedge monitor pops one record per cycle the loader is active.
module tb_fir_stream_loader;
  localparam int L  = 20;
  localparam int S  = 20;
  localparam int LD = 5;
  localparam int NW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] num_samples = '0;
  logic [7:0]    coeff_in = '0;
  logic          coeff_valid = 1'b0;
  logic          coeff_ready;
  logic [7:0]    sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          load_coefficients_flag, load_data_flag, stop_data_load_flag;
  logic [7:0]    coefficient_out, data_out;
  logic          busy, done, underrun;

  always #5 clock = ~clock;

  fir_stream_loader #(
    .LENGTH(L), .COEFF_W(8), .DATA_W(8), .CNT_W(NW), .SETTLE_CYCLES(S), .LEAD_CYCLES(LD)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_samples(num_samples),
    .coeff_in(coeff_in), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .load_coefficients_flag(load_coefficients_flag), .load_data_flag(load_data_flag),
    .stop_data_load_flag(stop_data_load_flag), .coefficient_out(coefficient_out),
    .data_out(data_out), .busy(busy), .done(done), .underrun(underrun)
  );

  typedef struct packed {
    logic       bsy, lc, ld, stp, dn, sr;
    logic [7:0] co;
    logic [7:0] dout;
  } rec_t;

  rec_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] coeff_vec [L];
  logic [7:0] samp_vec[$];
  bit         pat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {coeff_ready, sample_ready, load_coefficients_flag, load_data_flag,
            stop_data_load_flag, busy, done, underrun, coefficient_out, data_out};
  endfunction

  // Trace index 0 is the cycle load_coefficients_flag rises; the last entry is the done cycle.
  task automatic push_expected(input int n);
    logic [7:0] slot[$];
    int vc, ds, tt;
    rec_t r;
    vc = 0;
    for (int k = 0; k < n; k++) begin
      if (pat[k]) begin
        slot.push_back(samp_vec[vc]);
        vc++;
      end else begin
        slot.push_back(8'h00);
      end
    end
    ds = L + S + 1 + LD;
    tt = ds + n + L;
    for (int t = 0; t <= tt; t++) begin
      r.bsy  = (t < tt);
      r.lc   = (t < tt);
      r.ld   = (t >= L + S + 1) && (t < tt);
      r.stp  = (t == tt - 1);
      r.dn   = (t == tt);
      r.sr   = (t >= ds) && (t < ds + n);
      r.co   = (t >= 1 && t <= L) ? coeff_vec[t-1] : 8'h00;
      r.dout = (t >= ds + 1 && t <= ds + n) ? slot[t-ds-1] : 8'h00;
      exp_q.push_back(r);
    end
  endtask

  always @(negedge clock) begin
    rec_t act, e;
    if (!reset) begin
      act = {busy, load_coefficients_flag, load_data_flag, stop_data_load_flag, done,
             sample_ready, coefficient_out, data_out};
      if (load_coefficients_flag || load_data_flag || stop_data_load_flag || done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_unexpected act=%h req=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL stream_cycle act=%h req=%h", act, e);
          end
        end
      end else begin
        checks++;
        if (sample_ready !== 1'b0) begin
          failures++;
          $display("FAIL sample_ready_outside act=%b req=0", sample_ready);
        end
      end
    end
  end

  task automatic set_samples(input int n, input int valid_pct);
    samp_vec.delete();
    pat.delete();
    for (int k = 0; k <= n; k++) samp_vec.push_back(8'($urandom));
    for (int k = 0; k < n; k++) pat.push_back($urandom_range(99) < valid_pct);
  endtask

  task automatic run_test(input int n, input int coeff_pct, input bit reset_mid, input bit start_in_pad);
    int j, p, k, t, cyc, ds;
    bit seen_lc, fin, exp_und;
    ds = L + S + 1 + LD;
    exp_und = 1'b0;
    for (int i = 0; i < n; i++) if (!pat[i]) exp_und = 1'b1;
    push_expected(n);
    @(posedge clock); #1;
    start = 1'b1;
    num_samples = NW'(n);
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("underrun_cleared", underrun, 0);
    j = 0; p = 0; k = 0; t = 0; cyc = 0;
    seen_lc = 1'b0;
    fin = 1'b0;
    while (!fin) begin
      if (load_coefficients_flag && !seen_lc) begin
        seen_lc = 1'b1;
        t = 0;
      end else if (seen_lc) begin
        t++;
      end
      if (done) begin
        fin = 1'b1;
        check("underrun_at_done", underrun, 32'(exp_und));
      end else if (reset_mid && seen_lc && t == ds + n / 2) begin
        reset = 1'b1;
        #1;
        check("reset_mid_outputs", all_outputs(), 0);
        exp_q.delete();
        coeff_valid = 1'b0;
        sample_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        fin = 1'b1;
      end else begin
        start = 1'b0;
        if (start_in_pad && seen_lc && t == ds + n + 3) begin
          start = 1'b1;
          num_samples = NW'(5);
        end
        if (coeff_ready && j < L) begin
          coeff_valid = ($urandom_range(99) < coeff_pct);
          coeff_in = coeff_vec[j];
          if (coeff_valid) j++;
        end else begin
          coeff_valid = 1'($urandom_range(1));
          coeff_in = 8'($urandom);
        end
        if (sample_ready && k < n) begin
          sample_valid = pat[k];
          sample_in = (p < samp_vec.size()) ? samp_vec[p] : 8'h00;
          if (pat[k]) p++;
          k++;
        end else begin
          sample_valid = 1'($urandom_range(1));
          sample_in = 8'($urandom);
        end
        @(posedge clock); #1;
        cyc++;
        if (cyc > 3000) begin
          checks++;
          failures++;
          $display("FAIL run_timeout act=no_done req=done");
          fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    coeff_valid = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("trace_drained", exp_q.size(), 0);
    check("idle_after_run", busy, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check("reset_state", all_outputs(), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reference run: fixed coefficient prefix/suffix, ramp of 33 samples, no stalls.
    for (int i = 0; i < L; i++) coeff_vec[i] = 8'($urandom);
    coeff_vec[0] = 8'd34; coeff_vec[1] = 8'd34; coeff_vec[2] = 8'd0;
    coeff_vec[3] = 8'd49; coeff_vec[L-1] = 8'd10;
    samp_vec.delete();
    pat.delete();
    for (int k = 0; k < 33; k++) begin
      samp_vec.push_back(8'(10 + (159 * k) / 32));
      pat.push_back(1'b1);
    end
    run_test(33, 100, 1'b0, 1'b0);

    // Upstream coefficient stalls.
    for (int i = 0; i < L; i++) coeff_vec[i] = 8'($urandom);
    set_samples(8, 100);
    run_test(8, 50, 1'b0, 1'b0);

    // Two missing samples mid-stream.
    set_samples(10, 100);
    pat[4] = 1'b0;
    pat[5] = 1'b0;
    run_test(10, 100, 1'b0, 1'b0);

    // Empty sample block.
    set_samples(0, 100);
    run_test(0, 80, 1'b0, 1'b0);

    // Reset in the middle of the data stream, then a clean run.
    set_samples(12, 100);
    run_test(12, 100, 1'b1, 1'b0);
    for (int i = 0; i < L; i++) coeff_vec[i] = 8'($urandom);
    set_samples(6, 100);
    run_test(6, 100, 1'b0, 1'b0);

    // Start pulse during padding must be ignored.
    set_samples(7, 100);
    run_test(7, 100, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(15);
      for (int i = 0; i < L; i++) coeff_vec[i] = 8'($urandom);
      set_samples(n, 80);
      run_test(n, 70, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
